// File: rtl/shift_job_sequencer.sv
// Two-requester round-robin arbiter that programs the shift peripheral over its
// cs/we/reg_sel bus, waits out the shift, reads the result and returns it.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | no job; arbitrate and ack one requester
// S_WR_INFO | write {dir, 11'b0, times} to the info register
// S_WR_ORIG | write the operand to the original register
// S_START   | pulse restart (sel=11), load the wait counter
// S_WAIT    | count down times+LAT cycles with sel parked on result
// S_READ    | capture the result from sh_data_out
// S_RSP     | present the result until rsp_ready
module shift_job_sequencer #(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req0_dir,
    input  logic [3:0]  req0_times,
    input  logic [15:0] req0_value,
    output logic        req0_ack,
    input  logic        req1_valid,
    input  logic        req1_dir,
    input  logic [3:0]  req1_times,
    input  logic [15:0] req1_value,
    output logic        req1_ack,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_data,
    output logic        busy,
    output logic        sh_cs,
    output logic        sh_we,
    output logic [1:0]  sh_reg_sel,
    output logic [15:0] sh_data_in,
    input  logic [15:0] sh_data_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_INFO,
        S_WR_ORIG,
        S_START,
        S_WAIT,
        S_READ,
        S_RSP
    } state_t;

    state_t      state, state_nxt;
    logic        last_grant;
    logic        job_dir;
    logic [3:0]  job_times;
    logic [15:0] job_value;
    logic        job_id;
    logic [4:0]  wait_cnt;
    logic [15:0] rsp_data_q;
    logic        grant0, grant1;

    assign rsp_id   = job_id;
    assign rsp_data = rsp_data_q;

    always_comb begin
        state_nxt  = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        req0_ack   = 1'b0;
        req1_ack   = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        sh_cs      = 1'b0;
        sh_we      = 1'b0;
        sh_reg_sel = 2'b00;
        sh_data_in = 16'h0000;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                // Gated by reset so the acks stay low while reset is held.
                if (reset) begin
                    if (req0_valid && (!req1_valid || last_grant)) begin
                        grant0 = 1'b1;
                    end else if (req1_valid) begin
                        grant1 = 1'b1;
                    end
                end
                req0_ack = grant0;
                req1_ack = grant1;
                if (grant0 || grant1) begin
                    state_nxt = S_WR_INFO;
                end
            end
            S_WR_INFO: begin
                sh_cs      = 1'b1;
                sh_we      = 1'b1;
                sh_reg_sel = 2'b00;
                sh_data_in = {job_dir, 11'b0, job_times};
                state_nxt  = S_WR_ORIG;
            end
            S_WR_ORIG: begin
                sh_cs      = 1'b1;
                sh_we      = 1'b1;
                sh_reg_sel = 2'b01;
                sh_data_in = job_value;
                state_nxt  = S_START;
            end
            S_START: begin
                sh_cs      = 1'b1;
                sh_reg_sel = 2'b11;
                state_nxt  = S_WAIT;
            end
            S_WAIT: begin
                // Parked on result: holding sel=11 would keep the shifter in restart.
                sh_cs      = 1'b1;
                sh_reg_sel = 2'b10;
                if (wait_cnt == 5'd1) begin
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                sh_cs      = 1'b1;
                sh_reg_sel = 2'b10;
                state_nxt  = S_RSP;
            end
            S_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            job_dir    <= 1'b0;
            job_times  <= 4'd0;
            job_value  <= 16'h0000;
            job_id     <= 1'b0;
            wait_cnt   <= 5'd0;
            rsp_data_q <= 16'h0000;
        end else begin
            state <= state_nxt;
            if (grant0) begin
                job_dir    <= req0_dir;
                job_times  <= req0_times;
                job_value  <= req0_value;
                job_id     <= 1'b0;
                last_grant <= 1'b0;
            end else if (grant1) begin
                job_dir    <= req1_dir;
                job_times  <= req1_times;
                job_value  <= req1_value;
                job_id     <= 1'b1;
                last_grant <= 1'b1;
            end
            if (state == S_START) begin
                wait_cnt <= {1'b0, job_times} + 5'(LAT);
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt - 5'd1;
            end
            if (state == S_READ) begin
                rsp_data_q <= sh_data_out;
            end
        end
    end

endmodule
